// File: rtl/datapath_controller.sv
// Instruction-decode FSM for the 16-bit datapath. It latches an instruction on a start
// handshake and sequences the regfile, A/B/C/status loads, shifter and ALU controls.
module datapath_controller #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s,
  input  logic [15:0]   instr,
  output logic          w,
  output logic          err,
  output logic [2:0]    readnum,
  output logic [2:0]    writenum,
  output logic          write,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          asel,
  output logic          bsel,
  output logic          vsel,
  output logic [1:0]    shift,
  output logic [1:0]    ALUop,
  output logic [DW-1:0] imm_out
);

  typedef enum logic [2:0] {
    WAIT, DECODE, WIMM, GETA, GETB, EXEC, WRB
  } state_t;

  typedef struct packed {
    logic       w;
    logic       err;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       vsel;
  } ctl_t;

  state_t      state;
  logic [15:0] ir;
  ctl_t        ctl;

  function automatic logic is_movimm(input logic [15:0] i);
    return i[15:11] == 5'b11010;
  endfunction

  function automatic logic is_movreg(input logic [15:0] i);
    return i[15:11] == 5'b11000;
  endfunction

  function automatic logic is_alu(input logic [15:0] i);
    return i[15:13] == 3'b101;
  endfunction

  // Control word presented while the FSM sits in a given state with a given IR.
  function automatic ctl_t ctl_for(input state_t st, input logic [15:0] i);
    ctl_t c;
    c = '0;
    case (st)
      WAIT:   c.w = 1'b1;
      DECODE: c.err = !(is_movimm(i) || is_movreg(i) || is_alu(i));
      WIMM: begin
        c.writenum = i[10:8];
        c.vsel     = 1'b1;
        c.write    = 1'b1;
      end
      GETA: begin
        c.readnum = i[10:8];
        c.loada   = 1'b1;
      end
      GETB: begin
        c.readnum = i[2:0];
        c.loadb   = 1'b1;
      end
      EXEC: begin
        c.loadc = 1'b1;
        c.asel  = is_movreg(i) || (is_alu(i) && i[12:11] == 2'b11);
        c.loads = is_alu(i) && i[12:11] == 2'b01;
      end
      WRB: begin
        c.writenum = i[7:5];
        c.write    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic state_t next_of(input state_t st, input logic [15:0] i);
    state_t n;
    n = WAIT;
    case (st)
      DECODE: begin
        if (is_movimm(i))      n = WIMM;
        else if (is_movreg(i)) n = GETB;
        else if (is_alu(i))    n = GETA;
        else                   n = WAIT;
      end
      GETA:    n = GETB;
      GETB:    n = EXEC;
      EXEC:    n = (is_alu(i) && i[12:11] == 2'b01) ? WAIT : WRB;
      default: n = WAIT;
    endcase
    return n;
  endfunction

  // Outputs are registered alongside the state so they always reflect the state just entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT;
      ir    <= '0;
      ctl   <= ctl_for(WAIT, 16'h0000);
    end else if (state == WAIT) begin
      if (s) begin
        state <= DECODE;
        ir    <= instr;
        ctl   <= ctl_for(DECODE, instr);
      end
    end else begin
      state <= next_of(state, ir);
      ctl   <= ctl_for(next_of(state, ir), ir);
    end
  end

  assign w        = ctl.w;
  assign err      = ctl.err;
  assign readnum  = ctl.readnum;
  assign writenum = ctl.writenum;
  assign write    = ctl.write;
  assign loada    = ctl.loada;
  assign loadb    = ctl.loadb;
  assign loadc    = ctl.loadc;
  assign loads    = ctl.loads;
  assign asel     = ctl.asel;
  assign bsel     = ctl.bsel;
  assign vsel     = ctl.vsel;

  assign ALUop   = ir[12:11];
  assign shift   = is_movimm(ir) ? 2'b00 : ir[4:3];
  assign imm_out = {{(DW-8){ir[7]}}, ir[7:0]};

endmodule
